// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding and
// default PC parameters.
package if_pkg;

    localparam int unsigned IF_STATE_W = 2;

    localparam logic [IF_STATE_W-1:0] IF_REQ  = 2'd0;
    localparam logic [IF_STATE_W-1:0] IF_WAIT = 2'd1;
    localparam logic [IF_STATE_W-1:0] IF_DROP = 2'd2;

    localparam logic [31:0] IF_DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned IF_DEFAULT_PC_STEP  = 4;

endpackage : if_pkg

// File: rtl/if_pc_gen.sv
// Program counter register for the fetch stage: sequential increment on an
// accepted request, overridden by a redirect target.
module if_pc_gen
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_DEFAULT_RESET_PC),
    parameter int unsigned     PC_STEP  = IF_DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_step_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus_step;

    // Wraps modulo 2^XLEN by construction.
    assign pc_plus_step = pc_q + XLEN'(PC_STEP);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_plus_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o           = pc_q;
    assign pc_plus_step_o = pc_plus_step;

endmodule : if_pc_gen

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one-outstanding imem request FSM and IF/ID output slot.
// Defining IF_PERF_CNT_EN adds the fetch and stall performance counters.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_DEFAULT_RESET_PC),
    parameter int unsigned     PC_STEP  = IF_DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_nextpc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    logic [IF_STATE_W-1:0] state_q;
    logic [IF_STATE_W-1:0] state_d;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_step;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] req_nextpc_q;

    logic            id_valid_q;
    logic            id_valid_d;
    logic [ILEN-1:0] id_instr_q;
    logic [ILEN-1:0] id_instr_d;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] id_pc_d;
    logic [XLEN-1:0] id_nextpc_q;
    logic [XLEN-1:0] id_nextpc_d;

    logic slot_free;
    logic req_fire;
    logic rsp_accept;

    // Only issue when the slot will be empty by the time any response can land.
    assign slot_free      = !id_valid_q || id_ready;
    assign imem_req_valid = (state_q == IF_REQ) && !reset && !redirect_valid && slot_free;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    if_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .advance_i        (req_fire),
        .pc_o             (pc),
        .pc_plus_step_o   (pc_plus_step)
    );

    always_comb begin
        state_d    = state_q;
        rsp_accept = 1'b0;
        case (state_q)
            IF_REQ: begin
                if (req_fire) begin
                    state_d = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? IF_REQ : IF_DROP;
                end else if (imem_rsp_valid) begin
                    state_d    = IF_REQ;
                    rsp_accept = 1'b1;
                end
            end
            IF_DROP: begin
                // A response landing together with a new redirect is still the stale one.
                if (imem_rsp_valid) begin
                    state_d = IF_REQ;
                end
            end
            default: begin
                state_d = IF_REQ;
            end
        endcase
    end

    always_comb begin
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        id_nextpc_d = id_nextpc_q;
        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end
        if (rsp_accept) begin
            id_valid_d  = 1'b1;
            id_instr_d  = imem_rsp_data;
            id_pc_d     = req_pc_q;
            id_nextpc_d = req_nextpc_q;
        end
        if (redirect_valid) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IF_REQ;
            req_pc_q     <= '0;
            req_nextpc_q <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
            id_nextpc_q  <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                req_pc_q     <= pc;
                req_nextpc_q <= pc_plus_step;
            end
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            id_nextpc_q <= id_nextpc_d;
        end
    end

    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_nextpc = id_nextpc_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (rsp_accept) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (id_valid_q && !id_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule : if_fetch_stage

// File: doc/if_fetch_stage.md
# if_fetch_stage

Parametrised instruction-fetch stage for the pipelined core. It owns the program counter and issues fetch requests to instruction memory over a valid/ready request channel with variable response latency. It returns each fetched word with its PC and next PC through a one-entry IF/ID output register using valid/ready toward decode. Branch and jump redirects are taken from later stages.

## Interface
Parameters:
- `XLEN`, 32: PC and address width.
- `ILEN`, 32: instruction word width.
- `RESET_PC`, 0: PC value after reset.
- `PC_STEP`, 4: sequential PC increment.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  redirect request from EX/branch unit.
- `redirect_pc`  in  XLEN  redirect target.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  XLEN  fetch address (current PC).
- `imem_rsp_valid`  in  1  response valid, single-cycle pulse.
- `imem_rsp_data`  in  ILEN  fetched instruction.
- `id_valid`  out  1  IF/ID register holds an instruction.
- `id_ready`  in  1  decode consumes the instruction.
- `id_instr`  out  ILEN  instruction.
- `id_pc`  out  XLEN  address of `id_instr`.
- `id_nextpc`  out  XLEN  `id_pc + PC_STEP`.
- `perf_fetch_cnt`  out  32  present only with `IF_PERF_CNT_EN`.
- `perf_stall_cnt`  out  32  present only with `IF_PERF_CNT_EN`.

## Operation
- At most one outstanding request. FSM states: `REQ`, `WAIT`, `DROP`.
- `REQ`:
  - Drive `imem_req_valid = !redirect_valid && (!id_valid || id_ready)` with `imem_req_addr = pc`.
  - On handshake: capture `pc` as `req_pc`, set `pc <= pc + PC_STEP`, go to `WAIT`.
  - The issue gate guarantees the output slot is free when the response arrives, so responses are never lost.
- `WAIT`: on `imem_rsp_valid`, load `id_instr <= imem_rsp_data`, `id_pc <= req_pc`, `id_nextpc <= req_pc + PC_STEP`, `id_valid <= 1`, then go to `REQ`.
- `DROP`: discard the next `imem_rsp_valid`, then go to `REQ`.
- Output slot: `id_valid` clears on an `id_valid && id_ready` handshake unless it is reloaded in the same cycle.
- Redirect has highest priority in every state. It sets `pc <= redirect_pc` and clears `id_valid`. Then, by state:
  - `REQ`: no request is issued that cycle; stay in `REQ`.
  - `WAIT` without a response: go to `DROP`.
  - `WAIT` with a response in the same cycle: discard the response, go to `REQ`.
  - `DROP`: stay in `DROP`.
- `imem_rsp_valid` in `REQ` is ignored. It is a protocol error; memory shares `reset`.
- Arithmetic is modulo 2^XLEN: PC and next PC wrap silently.
- Reset: `pc = RESET_PC`, state `REQ`, `id_valid = 0`, `id_instr = 0`, `id_pc = 0`, `id_nextpc = 0`, counters 0. `imem_req_valid` is 0 while `reset` is high. Reset mid-`WAIT` or mid-`DROP` abandons the request.

## Timing
- A request accepted at edge N produces a response in cycle N+k (k ≥ 1). `id_valid` rises at the end of that cycle.
- With k = 1, sustained throughput is one instruction per 2 cycles.
- `redirect_valid` sampled at edge N puts `redirect_pc` on `imem_req_addr` in cycle N+1, provided the FSM is in `REQ`.
- Output registers hold stable while `id_valid && !id_ready`.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `perf_fetch_cnt` increments on each response delivered to the slot.
  - `perf_stall_cnt` increments each cycle `id_valid && !id_ready`.
  - Both wrap at 2^32.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package `if_pkg`:
  - FSM state encoding (`IF_REQ`, `IF_WAIT`, `IF_DROP`, 2 bits).
  - Default `PC_STEP` and `RESET_PC` constants.
- Sub-module `if_pc_gen`: PC register, increment, and redirect mux.
- FSM and output slot stay in the top module.

## Test plan
- Reset with `RESET_PC=0`, memory always ready → cycle after reset release: `imem_req_addr=0x0000_0000`, `id_valid=0`.
- 1-cycle memory returning `0x1111_0000+addr`, `id_ready=1` → `id_pc` sequence 0x0, 0x4, 0x8 with `id_nextpc` 0x4, 0x8, 0xC; one instruction every 2 cycles.
- Hold `id_ready=0` for 5 cycles with `id_valid=1` → `id_instr` and `id_pc` stable, `imem_req_valid=0`, `perf_stall_cnt=5`.
- Redirect to 0x100 while in `WAIT` with 3-cycle latency → stale response dropped, `id_valid` stays 0, next request address 0x100.
- `RESET_PC=0xFFFF_FFFC` → first `id_nextpc=0x0000_0000`, second request address 0x0.
- Assert `reset` mid-`WAIT` → next cycle all outputs at reset values, state `REQ`, first request at `RESET_PC`.
